// File: rtl/collision_engine.sv
// Pac-Man collision engine: tracks NORMAL/FRIGHT/DYING, eats ghosts with combo scoring, signals deaths.
// Optional macro COLLISION_CROSS_EN also detects pac/ghost position swaps between frame ticks.
module collision_engine #(
  parameter int N_GHOSTS          = 4,
  parameter int POS_W             = 13,
  parameter int FRIGHT_FRAMES     = 360,
  parameter int WARN_FRAMES       = 120,
  parameter int DEATH_LOCK_FRAMES = 60
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_tick,
  input  logic [POS_W-1:0]          pac_pos,
  input  logic [N_GHOSTS*POS_W-1:0] ghost_pos,
  input  logic                      pellet_eaten,
  input  logic [N_GHOSTS-1:0]       ghost_home,
  output logic                      eat_time,
  output logic                      fright_warn,
  output logic [N_GHOSTS-1:0]       ghost_eaten,
  output logic [10:0]               score_add,
  output logic                      pac_death,
  output logic [N_GHOSTS-1:0]       eaten_mask
);
  localparam int MAX_FRAMES = (FRIGHT_FRAMES > DEATH_LOCK_FRAMES) ? FRIGHT_FRAMES : DEATH_LOCK_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;
  localparam logic [CNT_W-1:0] FRIGHT_LOAD = CNT_W'(FRIGHT_FRAMES);
  localparam logic [CNT_W-1:0] DEATH_LOAD  = CNT_W'(DEATH_LOCK_FRAMES);
  localparam logic [CNT_W-1:0] WARN_LEVEL  = CNT_W'(WARN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {ST_NORMAL, ST_FRIGHT, ST_DYING} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          combo_q, combo_d, combo_base;
  logic [N_GHOSTS-1:0] mask_q, mask_d;
  logic [N_GHOSTS-1:0] ghost_eaten_q, ghost_eaten_d;
  logic [10:0]         score_q, score_d;
  logic                pac_death_q, pac_death_d;
  logic                eat_time_q, fright_warn_q;
  logic                eval_eat;
  logic [N_GHOSTS-1:0] hit, eat_oh;

`ifdef COLLISION_CROSS_EN
  logic [POS_W-1:0]          prev_pac_q;
  logic [N_GHOSTS*POS_W-1:0] prev_ghost_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      prev_pac_q   <= '0;
      prev_ghost_q <= '0;
    end else if (frame_tick) begin
      prev_pac_q   <= pac_pos;
      prev_ghost_q <= ghost_pos;
    end
  end
`endif

  // Ghosts already reduced to eyes never collide.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      hit[i] = (pac_pos == ghost_pos[i*POS_W +: POS_W]);
`ifdef COLLISION_CROSS_EN
      if ((pac_pos == prev_ghost_q[i*POS_W +: POS_W]) &&
          (ghost_pos[i*POS_W +: POS_W] == prev_pac_q))
        hit[i] = 1'b1;
`endif
      hit[i] = hit[i] & ~mask_q[i];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    combo_d       = combo_q;
    combo_base    = combo_q;
    mask_d        = mask_q;
    ghost_eaten_d = '0;
    score_d       = '0;
    pac_death_d   = 1'b0;
    eval_eat      = 1'b0;
    eat_oh        = '0;
    if (frame_tick) begin
      mask_d = mask_q & ~ghost_home;
      unique case (state_q)
        ST_NORMAL: begin
          if (pellet_eaten) begin
            state_d    = ST_FRIGHT;
            cnt_d      = FRIGHT_LOAD;
            combo_base = '0;
            eval_eat   = 1'b1;
          end else if (|hit) begin
            pac_death_d = 1'b1;
            state_d     = ST_DYING;
            cnt_d       = DEATH_LOAD;
          end
        end
        ST_FRIGHT: begin
          eval_eat = 1'b1;
          if (pellet_eaten) begin
            cnt_d      = FRIGHT_LOAD;
            combo_base = '0;
          end else if (cnt_q <= CNT_ONE) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DYING: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
            mask_d  = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: state_d = ST_NORMAL;
      endcase
      // Only the lowest-index hit ghost is eaten; the rest wait for later ticks.
      if (eval_eat) begin
        combo_d = combo_base;
        eat_oh  = hit & (~hit + N_GHOSTS'(1));
        if (|hit) begin
          ghost_eaten_d = eat_oh;
          mask_d        = mask_d | eat_oh;
          score_d       = 11'd200 << combo_base;
          combo_d       = (combo_base == 2'd3) ? 2'd3 : combo_base + 2'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q       <= ST_NORMAL;
      cnt_q         <= '0;
      combo_q       <= '0;
      mask_q        <= '0;
      ghost_eaten_q <= '0;
      score_q       <= '0;
      pac_death_q   <= 1'b0;
      eat_time_q    <= 1'b0;
      fright_warn_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      combo_q       <= combo_d;
      mask_q        <= mask_d;
      ghost_eaten_q <= ghost_eaten_d;
      score_q       <= score_d;
      pac_death_q   <= pac_death_d;
      eat_time_q    <= (state_d == ST_FRIGHT);
      fright_warn_q <= (state_d == ST_FRIGHT) && (cnt_d <= WARN_LEVEL);
    end
  end

  assign eat_time    = eat_time_q;
  assign fright_warn = fright_warn_q;
  assign ghost_eaten = ghost_eaten_q;
  assign score_add   = score_q;
  assign pac_death   = pac_death_q;
  assign eaten_mask  = mask_q;

endmodule

// File: tb/tb_collision_engine.sv
// Self-checking bench for collision_engine: directed scenarios plus random ticks against a frame-level model.
module tb_collision_engine;
  localparam int NG = 4;
  localparam int PW = 13;
  localparam int FF = 360;
  localparam int WF = 120;
  localparam int DF = 60;
  localparam int M_NORMAL = 0, M_FRIGHT = 1, M_DYING = 2;
`ifdef COLLISION_CROSS_EN
  localparam bit CROSS = 1'b1;
`else
  localparam bit CROSS = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset_n, frame_tick, pellet_eaten;
  logic [PW-1:0]    pac_pos;
  logic [NG*PW-1:0] ghost_pos;
  logic [NG-1:0]    ghost_home;
  logic             eat_time, fright_warn, pac_death;
  logic [NG-1:0]    ghost_eaten, eaten_mask;
  logic [10:0]      score_add;

  collision_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .pac_pos(pac_pos),
    .ghost_pos(ghost_pos), .pellet_eaten(pellet_eaten), .ghost_home(ghost_home),
    .eat_time(eat_time), .fright_warn(fright_warn), .ghost_eaten(ghost_eaten),
    .score_add(score_add), .pac_death(pac_death), .eaten_mask(eaten_mask)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus for the next tick.
  int          t_pac;
  int          t_g[NG];
  bit          t_pellet;
  bit [NG-1:0] t_home;

  // Frame-level reference model.
  int          m_mode, m_frames, m_combo;
  bit [NG-1:0] m_eaten;
  int          e_ge, e_sc, e_death, e_et, e_warn;
`ifdef COLLISION_CROSS_EN
  int          m_prev_pac;
  int          m_prev_g[NG];
`endif

  task automatic model_reset();
    m_mode = M_NORMAL; m_frames = 0; m_combo = 0; m_eaten = '0;
    e_ge = 0; e_sc = 0; e_death = 0; e_et = 0; e_warn = 0;
`ifdef COLLISION_CROSS_EN
    m_prev_pac = 0;
    foreach (m_prev_g[i]) m_prev_g[i] = 0;
`endif
  endtask

  task automatic model_tick();
    bit [NG-1:0] hits;
    bit try_eat;
    int first;
    for (int i = 0; i < NG; i++) begin
      hits[i] = (t_pac == t_g[i]);
`ifdef COLLISION_CROSS_EN
      if (t_pac == m_prev_g[i] && t_g[i] == m_prev_pac) hits[i] = 1'b1;
`endif
      if (m_eaten[i]) hits[i] = 1'b0;
      if (t_home[i]) m_eaten[i] = 1'b0;
    end
    e_ge = 0; e_sc = 0; e_death = 0; try_eat = 0;
    case (m_mode)
      M_NORMAL: begin
        if (t_pellet) begin
          m_mode = M_FRIGHT; m_frames = FF; m_combo = 0; try_eat = 1;
        end else if (hits != 0) begin
          e_death = 1; m_mode = M_DYING; m_frames = DF;
        end
      end
      M_FRIGHT: begin
        try_eat = 1;
        if (t_pellet) begin
          m_frames = FF; m_combo = 0;
        end else if (m_frames == 1) m_mode = M_NORMAL;
        else m_frames--;
      end
      default: begin
        if (m_frames <= 1) begin
          m_mode = M_NORMAL; m_eaten = '0;
        end else m_frames--;
      end
    endcase
    if (try_eat) begin
      first = -1;
      for (int i = NG - 1; i >= 0; i--) if (hits[i]) first = i;
      if (first >= 0) begin
        e_ge = 1 << first;
        m_eaten[first] = 1'b1;
        e_sc = 200 * (2 ** m_combo);
        m_combo = (m_combo < 3) ? m_combo + 1 : 3;
      end
    end
`ifdef COLLISION_CROSS_EN
    m_prev_pac = t_pac;
    m_prev_g = t_g;
`endif
    e_et   = (m_mode == M_FRIGHT) ? 1 : 0;
    e_warn = (m_mode == M_FRIGHT && m_frames <= WF) ? 1 : 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".eat_time"}, 32'(eat_time), 32'(e_et));
    check({tag, ".warn"}, 32'(fright_warn), 32'(e_warn));
    check({tag, ".ghost_eaten"}, 32'(ghost_eaten), 32'(e_ge));
    check({tag, ".score"}, 32'(score_add), 32'(e_sc));
    check({tag, ".death"}, 32'(pac_death), 32'(e_death));
    check({tag, ".mask"}, 32'(eaten_mask), 32'(m_eaten));
  endtask

  // Outputs sampled after an idle clock: pulses gone, levels unchanged.
  task automatic check_idle();
    check("idle.ghost_eaten", 32'(ghost_eaten), 0);
    check("idle.score", 32'(score_add), 0);
    check("idle.death", 32'(pac_death), 0);
    check("idle.eat_time", 32'(eat_time), 32'(e_et));
    check("idle.mask", 32'(eaten_mask), 32'(m_eaten));
  endtask

  task automatic do_tick(input string tag);
    @(negedge Clk);
    check_idle();
    pac_pos = PW'(t_pac);
    for (int i = 0; i < NG; i++) ghost_pos[i*PW +: PW] = PW'(t_g[i]);
    pellet_eaten = t_pellet;
    ghost_home   = t_home;
    frame_tick   = 1'b1;
    model_tick();
    @(negedge Clk);
    frame_tick = 1'b0; pellet_eaten = 1'b0; ghost_home = '0;
    compare_all(tag);
  endtask

  // Reset asserted together with a tick, pellet and hits; reset must win.
  task automatic do_reset(input string tag);
    @(negedge Clk);
    Reset_n = 1'b0; frame_tick = 1'b1; pellet_eaten = 1'b1; ghost_home = '1;
    pac_pos = '0; ghost_pos = '0;
    @(negedge Clk);
    Reset_n = 1'b1; frame_tick = 1'b0; pellet_eaten = 1'b0; ghost_home = '0;
    model_reset();
    check({tag, ".eat_time"}, 32'(eat_time), 0);
    check({tag, ".warn"}, 32'(fright_warn), 0);
    check({tag, ".ghost_eaten"}, 32'(ghost_eaten), 0);
    check({tag, ".score"}, 32'(score_add), 0);
    check({tag, ".death"}, 32'(pac_death), 0);
    check({tag, ".mask"}, 32'(eaten_mask), 0);
  endtask

  task automatic set_far();
    t_pac = 5; t_g = '{100, 200, 300, 400}; t_pellet = 0; t_home = '0;
  endtask

  initial begin
    Reset_n = 1'b1; frame_tick = 1'b0; pellet_eaten = 1'b0; ghost_home = '0;
    pac_pos = '0; ghost_pos = '0;
    model_reset();
    set_far();

    // Pellet and hit on one tick, then fright runs out with the mask kept.
    do_reset("rst0");
    t_g[0] = 5; t_pellet = 1;
    do_tick("pel_hit");
    check("pel_hit.ge", 32'(ghost_eaten), 32'h1);
    check("pel_hit.score", 32'(score_add), 200);
    t_pellet = 0; t_g[0] = 400;
    for (int k = 1; k <= 360; k++) begin
      do_tick("fright_run");
      if (k == 239) check("warn_before", 32'(fright_warn), 0);
      if (k == 240) check("warn_rise", 32'(fright_warn), 1);
      if (k == 359) check("fright_last", 32'(eat_time), 1);
      if (k == 360) begin
        check("fright_end", 32'(eat_time), 0);
        check("fright_end.mask", 32'(eaten_mask), 32'h1);
      end
    end

    // Eyes ignored, then a live ghost kills; lockout ignores pellets and hits.
    t_g[0] = 5;
    do_tick("eyes_safe");
    check("eyes_safe.death", 32'(pac_death), 0);
    t_g[0] = 400; t_g[1] = 5;
    do_tick("death");
    check("death.pulse", 32'(pac_death), 1);
    t_g[1] = 200;
    for (int k = 1; k <= 60; k++) begin
      t_pellet = (k == 1 || k == 59);
      t_g[2] = (k == 30) ? 5 : 300;
      do_tick("dying");
      if (k == 1 || k == 59) check("dying.pellet", 32'(eat_time), 0);
      if (k == 30) check("dying.nohit", 32'(pac_death), 0);
      if (k == 60) check("dying.exit_mask", 32'(eaten_mask), 0);
    end
    t_pellet = 1;
    do_tick("after_dying");
    check("after_dying.eat_time", 32'(eat_time), 1);

    // Reset mid-FRIGHT, then the basic death case, then reset mid-DYING.
    do_reset("rst_fright");
    set_far(); t_g[0] = 5;
    do_tick("basic_death");
    check("basic_death.pulse", 32'(pac_death), 1);
    check("basic_death.ge", 32'(ghost_eaten), 0);
    @(negedge Clk);
    check("basic_death.one_cycle", 32'(pac_death), 0);
    t_g[0] = 100;
    repeat (3) do_tick("dying_b");
    do_reset("rst_dying");
    set_far(); t_pellet = 1;
    do_tick("post_rst_pellet");
    check("post_rst_pellet.eat_time", 32'(eat_time), 1);

    // Two ghosts on pac in one tick are eaten on consecutive ticks.
    do_reset("rst_d");
    set_far(); t_pellet = 1;
    do_tick("pel_d");
    t_pellet = 0; t_g[1] = 5; t_g[2] = 5;
    do_tick("dual1");
    check("dual1.ge", 32'(ghost_eaten), 32'h2);
    check("dual1.score", 32'(score_add), 200);
    do_tick("dual2");
    check("dual2.ge", 32'(ghost_eaten), 32'h4);
    check("dual2.score", 32'(score_add), 400);
    do_tick("dual3");
    check("dual3.mask", 32'(eaten_mask), 32'h6);

    // Combo ladder, pellet restarting combo, home clearing vs same-tick eat.
    do_reset("rst_e");
    set_far(); t_pellet = 1;
    do_tick("pel_e");
    t_pellet = 0;
    t_g[0] = 5; do_tick("combo1"); check("combo1.score", 32'(score_add), 200);
    t_g[1] = 5; do_tick("combo2"); check("combo2.score", 32'(score_add), 400);
    t_g[2] = 5; do_tick("combo3"); check("combo3.score", 32'(score_add), 800);
    t_g[3] = 5; t_pellet = 1; do_tick("combo4"); check("combo4.score", 32'(score_add), 200);
    t_pellet = 0; t_g[0] = 100; t_home = 4'b0001;
    do_tick("home"); check("home.mask", 32'(eaten_mask), 32'he);
    t_g[0] = 5;
    do_tick("home_eat");
    check("home_eat.ge", 32'(ghost_eaten), 32'h1);
    check("home_eat.mask", 32'(eaten_mask), 32'hf);
    check("home_eat.score", 32'(score_add), 400);

    // Swap of pac and ghost 0 between ticks.
    do_reset("rst_f");
    set_far(); t_pac = 10; t_g[0] = 11;
    do_tick("cross1");
    t_pac = 11; t_g[0] = 10;
    do_tick("cross2");
    check("cross2.death", 32'(pac_death), 32'(CROSS));

    // Random traffic on a tiny board so collisions are frequent.
    do_reset("rst_rand");
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) do_reset("rst_rnd");
      t_pac = int'($urandom_range(0, 3));
      for (int i = 0; i < NG; i++) begin
        t_g[i] = int'($urandom_range(0, 5));
        t_home[i] = ($urandom_range(0, 7) == 0);
      end
      t_pellet = ($urandom_range(0, 299) == 0);
      do_tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/collision_engine.md
COLLISION_ENGINE -- requirements
Module: collision_engine

Interface
REQ-001 SHALL have parameter N_GHOSTS, default 4, number of ghost channels (1..8).
REQ-002 SHALL have parameter POS_W, default 13, width of one packed tile position.
REQ-003 SHALL have parameter FRIGHT_FRAMES, default 360, frightened duration in frame ticks.
REQ-004 SHALL have parameter WARN_FRAMES, default 120, remaining-frames threshold for flash warning (< FRIGHT_FRAMES).
REQ-005 SHALL have parameter DEATH_LOCK_FRAMES, default 60, post-death lockout in frame ticks.
REQ-006 SHALL have port Clk  input  1  system clock; all state on rising edge; one clock only.
REQ-007 SHALL have port Reset_n  input  1  synchronous active-low reset.
REQ-008 SHALL have port frame_tick  input  1  one-cycle strobe; evaluation happens only on it.
REQ-009 SHALL have port pac_pos  input  POS_W  Pac-Man tile position.
REQ-010 SHALL have port ghost_pos  input  N_GHOSTS*POS_W  ghost i at bits [i*POS_W +: POS_W].
REQ-011 SHALL have port pellet_eaten  input  1  power-pellet event, sampled on frame_tick.
REQ-012 SHALL have port ghost_home  input  N_GHOSTS  per-ghost respawn event, sampled on frame_tick.
REQ-013 SHALL have port eat_time  output  1  high while in FRIGHT.
REQ-014 SHALL have port fright_warn  output  1  high in FRIGHT when remaining frames <= WARN_FRAMES.
REQ-015 SHALL have port ghost_eaten  output  N_GHOSTS  one-hot, one-cycle pulse.
REQ-016 SHALL have port score_add  output  11  points for current ghost_eaten pulse, else 0.
REQ-017 SHALL have port pac_death  output  1  one-cycle pulse on lethal collision.
REQ-018 SHALL have port eaten_mask  output  N_GHOSTS  ghosts currently eaten (eyes), ignored for collision.

Function
REQ-019 SHALL implement states NORMAL, FRIGHT, DYING; no state change except on frame_tick.
REQ-020 SHALL define hit[i] = (pac_pos == ghost i pos) AND NOT eaten_mask[i].
REQ-021 SHALL register all outputs; responses appear the cycle after the frame_tick cycle; pulses last exactly one cycle.
REQ-022 NORMAL: pellet_eaten -> FRIGHT, frame counter = FRIGHT_FRAMES, combo = 0.
REQ-023 NORMAL without pellet: any hit -> pac_death pulse, DYING, lock counter = DEATH_LOCK_FRAMES.
REQ-024 Pellet and hit on same tick in NORMAL: pellet wins; hit evaluated with FRIGHT rules at combo 0.
REQ-025 FRIGHT: lowest-index hit ghost only is eaten per tick; ghost_eaten[i] pulses, eaten_mask[i] set, score_add = 200 << combo.
REQ-026 combo SHALL increment after each eat, saturating at 3 (score 200/400/800/1600).
REQ-027 FRIGHT: counter decrements each tick; at 1 with no pellet -> NORMAL next tick; eaten_mask retained.
REQ-028 FRIGHT: pellet_eaten restarts counter at FRIGHT_FRAMES and resets combo to 0 before that tick's eat.
REQ-029 ghost_home[i] SHALL clear eaten_mask[i] in any state; if ghost i is eaten on the same tick, the eat wins.
REQ-030 DYING: no collision or pellet evaluation; counter decrements; at 1 -> NORMAL with eaten_mask cleared.
REQ-031 Remaining-hit ghosts overlapping in FRIGHT SHALL be eaten on subsequent ticks, one per tick.
REQ-032 Counter width SHALL be $clog2 of the larger of FRIGHT_FRAMES, DEATH_LOCK_FRAMES, plus 1.

Reset
REQ-033 Reset_n low at a rising edge SHALL force NORMAL, counters 0, combo 0, eaten_mask 0, all outputs 0, overriding frame_tick, also mid-FRIGHT or mid-DYING.

Configuration
REQ-034 Macro COLLISION_CROSS_EN defined: register previous pac_pos/ghost_pos on each tick; hit[i] also true when pac and ghost i swapped positions since the previous tick. Not defined: equality only, no position history registers.

Verification
REQ-035 Reset, pac_pos=5, ghost0=5, tick -> pac_death=1 one cycle after, state DYING, all other outputs 0.
REQ-036 pellet tick, then ghosts 1 and 2 both at pac on one tick -> ghost_eaten=0010 score 200, next tick 0100 score 400.
REQ-037 FRIGHT, 4 successive eats with pellet re-eaten before the 4th -> scores 200,400,800 then 200.
REQ-038 pellet, 240 ticks idle -> fright_warn rises; after 360 total ticks eat_time=0; eaten_mask unchanged.
REQ-039 Death, 60 ticks, no hits -> state NORMAL, eaten_mask=0; pellet during DYING ignored (eat_time stays 0).
REQ-040 COLLISION_CROSS_EN: tick1 pac=10 ghost0=11, tick2 pac=11 ghost0=10 -> pac_death=1; undefined -> no pulse.
